// File: rtl/switch_log_pkg.sv
// Shared types and defaults for the switch event logger.
//   evt_type_t   : event classification carried in each record
//   switch_evt_t : one FIFO record {typ, dur[, ts]}
// Optional feature macro: SWITCH_LOG_TIMESTAMP_EN adds a 32-bit ts field.
// The dur field is DUR_W_MAX bits wide; the logger zero-extends its
// DUR_W-bit duration into it, so DUR_W must not exceed DUR_W_MAX.
package switch_log_pkg;

  localparam int unsigned CLK_PER_MS_DEFAULT = 12000;
  localparam int unsigned LONG_MS_DEFAULT    = 500;
  localparam int unsigned DUR_W_MAX          = 32;

  typedef enum logic [1:0] {
    EVT_PRESS = 2'b00,
    EVT_SHORT = 2'b01,
    EVT_LONG  = 2'b10
  } evt_type_t;

  typedef struct packed {
    evt_type_t              typ;
    logic [DUR_W_MAX-1:0]   dur;
`ifdef SWITCH_LOG_TIMESTAMP_EN
    logic [31:0]            ts;
`endif
  } switch_evt_t;

endpackage

// File: rtl/switch_evt_fifo.sv
// First-word-fall-through FIFO of switch_evt_t records.
//   clk, rst_n : clock, asynchronous active-low reset (contents cleared)
//   push, din  : write request and record; ignored when full unless a pop
//                happens in the same cycle
//   full       : no free entry
//   pop        : consume the head; ignored when empty
//   dout       : head record, valid whenever empty = 0
//   empty      : no entry held
//   count      : entries held, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// Optional feature macro: SWITCH_LOG_TIMESTAMP_EN (widens switch_evt_t).
module switch_evt_fifo
  import switch_log_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  switch_evt_t                din,
  output logic                       full,
  input  logic                       pop,
  output switch_evt_t                dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  switch_evt_t   mem_q [DEPTH];
  switch_evt_t   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/switch_event_logger.sv
// Switch event logger: turns the debounced switch level into press /
// short-release / long-release records with a ms duration, queued in a
// FWFT FIFO drained over valid/ready.
//   clk, rst_n        : clock, asynchronous active-low reset
//   debounced_switch  : clean level, 1 = pressed
//   evt_valid/ready   : head handshake, pop on valid && ready
//   evt_type          : 00 press, 01 short release, 10 long release
//   evt_dur           : press duration in ms (0 for press), saturating
//   fifo_count        : entries held
//   overflow          : sticky, an event was dropped on a full FIFO
//   clr_overflow      : synchronous clear of overflow (a same-cycle drop wins)
//   evt_ts            : (SWITCH_LOG_TIMESTAMP_EN only) free-running ms
//                       counter value captured when the event was pushed
// Optional feature macro: SWITCH_LOG_TIMESTAMP_EN.
module switch_event_logger
  import switch_log_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = CLK_PER_MS_DEFAULT,
  parameter int unsigned DUR_W      = 16,
  parameter int unsigned LONG_MS    = LONG_MS_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          debounced_switch,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [1:0]                    evt_type,
  output logic [DUR_W-1:0]              evt_dur,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow
`ifdef SWITCH_LOG_TIMESTAMP_EN
  ,
  output logic [31:0]                   evt_ts
`endif
);

  localparam logic [1:0] ST_PRIME   = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_PRESSED = 2'd2;

  localparam int unsigned      PRE_W    = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);
  localparam logic [DUR_W-1:0] DUR_MAX  = '1;

  logic [1:0]       state_q, state_d;
  logic             sw_q, sw_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             overflow_q, overflow_d;
  logic             ms_tick;
  logic [DUR_W-1:0] dur_inc;
  logic             push;
  switch_evt_t      push_evt;
  switch_evt_t      head;
  logic             fifo_full, fifo_empty;
  logic             pop_fire;
  logic             unused_dur_bits;

  assign sw_d     = debounced_switch;
  assign pop_fire = evt_valid && evt_ready;

`ifdef SWITCH_LOG_TIMESTAMP_EN
  // Own free-running divider: the duration prescaler restarts on each press
  // and so cannot time-stamp against a continuous ms reference.
  logic [PRE_W-1:0] ts_pre_q, ts_pre_d;
  logic [31:0]      ts_cnt_q, ts_cnt_d;

  always_comb begin
    ts_pre_d = ts_pre_q + PRE_W'(1);
    ts_cnt_d = ts_cnt_q;
    if (ts_pre_q == PRE_LAST) begin
      ts_pre_d = '0;
      ts_cnt_d = ts_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_pre_q <= '0;
      ts_cnt_q <= '0;
    end else begin
      ts_pre_q <= ts_pre_d;
      ts_cnt_q <= ts_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    dur_d    = dur_q;
    push     = 1'b0;
    push_evt = '0;
    ms_tick  = (pre_q == PRE_LAST);
    // Release reports the count including a tick landing in the release cycle.
    dur_inc  = (ms_tick && (dur_q != DUR_MAX)) ? dur_q + DUR_W'(1) : dur_q;
`ifdef SWITCH_LOG_TIMESTAMP_EN
    push_evt.ts = ts_cnt_q;
`endif
    case (state_q)
      ST_PRIME: begin
        // sw_q still holds its reset value here, so decide from the live input.
        pre_d   = '0;
        dur_d   = '0;
        state_d = debounced_switch ? ST_PRESSED : ST_IDLE;
      end
      ST_IDLE: begin
        if (sw_q) begin
          push         = 1'b1;
          push_evt.typ = EVT_PRESS;
          pre_d        = '0;
          dur_d        = '0;
          state_d      = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        pre_d = ms_tick ? '0 : pre_q + PRE_W'(1);
        dur_d = dur_inc;
        if (!sw_q) begin
          push         = 1'b1;
          push_evt.typ = (32'(dur_inc) >= LONG_MS) ? EVT_LONG : EVT_SHORT;
          push_evt.dur = DUR_W_MAX'(dur_inc);
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_PRIME;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (push && fifo_full && !pop_fire) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PRIME;
      sw_q       <= 1'b0;
      pre_q      <= '0;
      dur_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sw_q       <= sw_d;
      pre_q      <= pre_d;
      dur_q      <= dur_d;
      overflow_q <= overflow_d;
    end
  end

  switch_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_evt),
    .full  (fifo_full),
    .pop   (evt_ready),
    .dout  (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign evt_valid = !fifo_empty;
  assign evt_type  = head.typ;
  assign evt_dur   = head.dur[DUR_W-1:0];
  assign overflow  = overflow_q;
`ifdef SWITCH_LOG_TIMESTAMP_EN
  assign evt_ts    = head.ts;
`endif

  // Upper dur bits beyond DUR_W are always zero.
  assign unused_dur_bits = ^head.dur;

endmodule

// File: tb/tb_switch_event_logger.sv
// Randomized self-checking bench for switch_event_logger. Two instances share
// all inputs: one with DUR_W=16 and one with DUR_W=8 (saturation). A queue
// model built from the event rules predicts every output each cycle.
// Optional feature macro: SWITCH_LOG_TIMESTAMP_EN (evt_ts checked if defined).
module tb_switch_event_logger;

  localparam int unsigned CPM   = 12;
  localparam int unsigned LONG  = 500;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic debounced_switch = 1'b0;
  logic evt_ready = 1'b0;
  logic clr_overflow = 1'b0;

  logic        evt_valid_a, evt_valid_b;
  logic [1:0]  evt_type_a, evt_type_b;
  logic [15:0] evt_dur_a;
  logic [7:0]  evt_dur_b;
  logic [3:0]  fifo_count_a, fifo_count_b;
  logic        overflow_a, overflow_b;
`ifdef SWITCH_LOG_TIMESTAMP_EN
  logic [31:0] evt_ts_a, evt_ts_b;
`endif

  always #5 clk = ~clk;

  switch_event_logger #(
    .CLK_PER_MS (CPM), .DUR_W (16), .LONG_MS (LONG), .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk (clk), .rst_n (rst_n), .debounced_switch (debounced_switch),
    .evt_valid (evt_valid_a), .evt_ready (evt_ready), .evt_type (evt_type_a),
    .evt_dur (evt_dur_a), .fifo_count (fifo_count_a), .overflow (overflow_a),
    .clr_overflow (clr_overflow)
`ifdef SWITCH_LOG_TIMESTAMP_EN
    , .evt_ts (evt_ts_a)
`endif
  );

  switch_event_logger #(
    .CLK_PER_MS (CPM), .DUR_W (8), .LONG_MS (LONG), .FIFO_DEPTH (DEPTH)
  ) u_dut8 (
    .clk (clk), .rst_n (rst_n), .debounced_switch (debounced_switch),
    .evt_valid (evt_valid_b), .evt_ready (evt_ready), .evt_type (evt_type_b),
    .evt_dur (evt_dur_b), .fifo_count (fifo_count_b), .overflow (overflow_b),
    .clr_overflow (clr_overflow)
`ifdef SWITCH_LOG_TIMESTAMP_EN
    , .evt_ts (evt_ts_b)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_press;
    int unsigned ms;   // unsaturated duration
    int unsigned ts;
  } mevt_t;

  mevt_t q[$];
  mevt_t pend;
  bit    pend_v;
  bit    ovf;
  bit    in_press;
  int    start;
  int    cyc;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned exp_dur(input mevt_t e, input int unsigned w);
    int unsigned lim;
    lim = (32'd1 << w) - 1;
    if (e.is_press) return 0;
    return (e.ms > lim) ? lim : e.ms;
  endfunction

  function automatic int unsigned exp_type(input mevt_t e, input int unsigned d);
    if (e.is_press) return 0;
    return (d >= LONG) ? 2 : 1;
  endfunction

  task automatic model_reset();
    q.delete();
    pend_v   = 1'b0;
    ovf      = 1'b0;
    in_press = 1'b0;
    start    = 0;
    cyc      = 0;
  endtask

  // One clock cycle of the model: FIFO traffic for this cycle (using the
  // event detected one cycle earlier), then edge detection on this cycle's level.
  task automatic model_edge(input bit s, input bit rdy, input bit clr);
    bit drop;
    int h;
    drop = 1'b0;
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (pend_v) begin
      if (q.size() < DEPTH) q.push_back(pend);
      else drop = 1'b1;
    end
    if (drop) ovf = 1'b1;
    else if (clr) ovf = 1'b0;
    pend_v = 1'b0;
    if (cyc == 0) begin
      // Held through reset: no press event, timed from reset release
      // with the first post-reset cycle counted.
      in_press = s;
      start    = -1;
    end else if (s && !in_press) begin
      pend_v   = 1'b1;
      pend     = '{is_press: 1'b1, ms: 0, ts: (cyc + 1) / CPM};
      in_press = 1'b1;
      start    = cyc;
    end else if (!s && in_press) begin
      h        = cyc - start;
      pend_v   = 1'b1;
      pend     = '{is_press: 1'b0, ms: h / CPM, ts: (cyc + 1) / CPM};
      in_press = 1'b0;
    end
    cyc++;
  endtask

  task automatic check_outputs();
    int unsigned da, db;
    chk("valid_a", evt_valid_a, q.size() != 0);
    chk("valid_b", evt_valid_b, q.size() != 0);
    chk("count_a", fifo_count_a, q.size());
    chk("count_b", fifo_count_b, q.size());
    chk("ovf_a", overflow_a, ovf);
    chk("ovf_b", overflow_b, ovf);
    if (q.size() != 0) begin
      da = exp_dur(q[0], 16);
      db = exp_dur(q[0], 8);
      chk("type_a", evt_type_a, exp_type(q[0], da));
      chk("dur_a", evt_dur_a, da);
      chk("type_b", evt_type_b, exp_type(q[0], db));
      chk("dur_b", evt_dur_b, db);
`ifdef SWITCH_LOG_TIMESTAMP_EN
      chk("ts_a", evt_ts_a, q[0].ts);
      chk("ts_b", evt_ts_b, q[0].ts);
`endif
    end
  endtask

  task automatic check_reset_state();
    chk("rst_valid", evt_valid_a | evt_valid_b, 0);
    chk("rst_count_a", fifo_count_a, 0);
    chk("rst_count_b", fifo_count_b, 0);
    chk("rst_ovf", overflow_a | overflow_b, 0);
    chk("rst_type_a", evt_type_a, 0);
    chk("rst_dur_a", evt_dur_a, 0);
    chk("rst_dur_b", evt_dur_b, 0);
`ifdef SWITCH_LOG_TIMESTAMP_EN
    chk("rst_ts", evt_ts_a | evt_ts_b, 0);
`endif
  endtask

  // ---------------- stimulus ----------------
  task automatic step(input bit s, input bit rdy, input bit clr);
    debounced_switch = s;
    evt_ready        = rdy;
    clr_overflow     = clr;
    @(posedge clk);
    model_edge(s, rdy, clr);
    #1;
    check_outputs();
  endtask

  task automatic hold(input bit s, input int unsigned n, input bit rdy);
    for (int unsigned i = 0; i < n; i++) step(s, rdy, 1'b0);
  endtask

  task automatic rhold(input bit s, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      step(s, ($urandom % 4) != 0, ($urandom % 16) == 0);
  endtask

  // Reset lands mid-cycle; release is 1 time unit after a rising edge.
  task automatic do_reset(input bit s);
    debounced_switch = s;
    evt_ready        = 1'b0;
    clr_overflow     = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_state();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset(1'b0);

    // idle 5 ms
    hold(1'b0, 60, 1'b0);

    // 100 ms short, 600 ms long, 300 ms (saturates the 8-bit instance)
    hold(1'b1, 1200, 1'b1);  hold(1'b0, 30, 1'b1);
    hold(1'b1, 7200, 1'b1);  hold(1'b0, 30, 1'b1);
    hold(1'b1, 3600, 1'b1);  hold(1'b0, 30, 1'b1);

    // 10 events into an 8-deep FIFO, then drain and clear overflow
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 20, 1'b0);
      hold(1'b0, 20, 1'b0);
    end
    hold(1'b0, 20, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // refill to full, then a push coinciding with a pop
    for (int i = 0; i < 4; i++) begin
      hold(1'b1, 15, 1'b0);
      hold(1'b0, 15, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    hold(1'b1, 3, 1'b0);
    hold(1'b1, 30, 1'b1);
    hold(1'b0, 30, 1'b1);

    // random levels, ready and overflow clears
    for (int i = 0; i < 60; i++) begin
      rhold(1'b1, $urandom_range(1, 60));
      rhold(1'b0, $urandom_range(1, 40));
    end
    hold(1'b0, 30, 1'b1);

    // reset mid-press with the switch held through it
    hold(1'b1, 100, 1'b0);
    do_reset(1'b1);
    hold(1'b1, 605, 1'b1);
    hold(1'b0, 30, 1'b1);

    // press at 37 ms after reset release
    do_reset(1'b0);
    hold(1'b0, 444, 1'b1);
    hold(1'b1, 50, 1'b1);
    hold(1'b0, 30, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
